// File: rtl/uart_tx_fifo_bridge_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_bridge_if
// CPU data-memory bus seen by the UART transmit bridge.
//
// Signals:
//   bus_addr   CPU data address (low 12 bits)
//   bus_wdata  CPU write data
//   bus_we     write strobe, qualified with bus_addr
//   bus_rdata  registered read data (driven by the peripheral)
//
// Modports:
//   master  CPU side (drives address/data/strobe, receives read data)
//   slave   peripheral side
// -----------------------------------------------------------------------------
interface uart_tx_fifo_bridge_if;
    logic [11:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_we;
    logic [15:0] bus_rdata;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_we,
        input  bus_rdata
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_we,
        output bus_rdata
    );
endinterface

// File: rtl/uart_tx_fifo_bridge.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_bridge
// Memory-mapped UART transmitter. CPU writes to the data word are queued in a
// circular FIFO and serialised back-to-back; the status word reports FIFO
// level, not_full, idle and a sticky overflow flag.
//
// Address map (relative to BASE_ADDR):
//   +0  status  read : {level[7:0], 5'b0, overflow, idle, not_full}
//               write: bit2 = 1 clears overflow
//   +1  data    write: push bus_wdata[DATA_BITS-1:0]; read: 0
//
// Ports:
//   clock   single clock
//   n_rst   synchronous active-low reset
//   bus     uart_tx_fifo_bridge_if.slave (addr / wdata / we / rdata)
//   tx      serial output, idle high (registered)
//   busy    FIFO non-empty or frame in progress (registered)
// -----------------------------------------------------------------------------
module uart_tx_fifo_bridge #(
    parameter logic [11:0] BASE_ADDR    = 12'h800,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 434,
    parameter int          DATA_BITS    = 8,
    parameter int          PARITY       = 0,
    parameter int          STOP_BITS    = 1
) (
    input  logic                        clock,
    input  logic                        n_rst,
    uart_tx_fifo_bridge_if.slave        bus,
    output logic                        tx,
    output logic                        busy
);

    localparam int          PTR_W     = $clog2(FIFO_DEPTH);
    localparam int          LVL_W     = PTR_W + 1;
    localparam int          BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam int          BIT_W     = 3;
    localparam logic [11:0] DATA_ADDR = BASE_ADDR + 12'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    logic [DATA_BITS-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic                   r_overflow;

    logic [BAUD_W-1:0]      r_baud_cnt;
    logic [BIT_W-1:0]       r_bit_cnt;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_parity;

    logic                   r_tx;
    logic                   r_busy;
    logic [15:0]            r_rdata;

    logic                   w_wr_data;
    logic                   w_wr_status;
    logic                   w_empty;
    logic                   w_full;
    logic                   w_idle;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_ovf_set;
    logic                   w_baud_last;
    logic                   w_stop_last;
    logic                   w_tx;
    logic [DATA_BITS-1:0]   w_head;
    logic [15:0]            w_status;
    logic                   w_unused_wdata;

    // ------------------------------------------------------------------
    // Bus decode and FIFO flags
    // ------------------------------------------------------------------
    assign w_wr_data   = bus.bus_we && (bus.bus_addr == DATA_ADDR);
    assign w_wr_status = bus.bus_we && (bus.bus_addr == BASE_ADDR);
    assign w_empty     = (r_level == '0);
    assign w_full      = (r_level == LVL_W'(FIFO_DEPTH));
    assign w_idle      = w_empty && (r_state == S_IDLE);
    assign w_head      = r_mem[r_rd_ptr];

    // A push into a full FIFO still fits when the serializer pops that cycle.
    assign w_push      = w_wr_data && (!w_full || w_pop);
    assign w_ovf_set   = w_wr_data && w_full && !w_pop;

    // Only the low DATA_BITS and bit 2 of the write data carry meaning.
    assign w_unused_wdata = ^bus.bus_wdata;

    // ------------------------------------------------------------------
    // Serializer FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of its inputs regardless of process order.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    assign w_baud_last = (r_baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
    assign w_stop_last = (r_state == S_STOP) && w_baud_last
                         && (r_bit_cnt == BIT_W'(STOP_BITS - 1));

    // ------------------------------------------------------------------
    // Serializer FSM: next-state logic
    // ------------------------------------------------------------------
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:   if (!w_empty) w_state_next = S_START;
            S_START:  if (w_baud_last) w_state_next = S_DATA;
            S_DATA:   if (w_baud_last && (r_bit_cnt == BIT_W'(DATA_BITS - 1)))
                          w_state_next = (PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_baud_last) w_state_next = S_STOP;
            // Back-to-back: the next queued byte starts without an idle gap.
            S_STOP:   if (w_stop_last)
                          w_state_next = w_empty ? S_IDLE : S_START;
            default:  w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Serializer FSM: outputs (line level and FIFO pop)
    // ------------------------------------------------------------------
    always_comb begin
        w_tx  = 1'b1;
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:   w_pop = !w_empty;
            S_START:  w_tx  = 1'b0;
            S_DATA:   w_tx  = r_shift[0];
            S_PARITY: w_tx  = r_parity;
            S_STOP:   w_pop = w_stop_last && !w_empty;
            default:  ;
        endcase
    end

    // ------------------------------------------------------------------
    // Bit timing: both counters restart on every state entry and stay
    // cleared while idle.
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if ((w_state_next != r_state) || (r_state == S_IDLE)) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (w_baud_last) begin
            r_baud_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + BIT_W'(1);
        end else begin
            r_baud_cnt <= r_baud_cnt + BAUD_W'(1);
        end
    end

    // Shift register loaded on pop; parity is precomputed from the whole
    // character so the PARITY state just replays it.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_shift  <= '0;
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_shift  <= w_head;
            r_parity <= (PARITY == 1) ? ~(^w_head) : (^w_head);
        end else if ((r_state == S_DATA) && w_baud_last) begin
            r_shift  <= r_shift >> 1;
        end
    end

    // ------------------------------------------------------------------
    // FIFO storage
    // ------------------------------------------------------------------
    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers and level, so stale contents are never observed.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.bus_wdata[DATA_BITS-1:0];
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: ;
            endcase
        end
    end

    // Sticky overflow; a new overflow in the clearing cycle takes priority.
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_overflow <= 1'b0;
        end else if (w_ovf_set) begin
            r_overflow <= 1'b1;
        end else if (w_wr_status && bus.bus_wdata[2]) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------
    assign w_status = {8'(r_level), 5'b0, r_overflow, w_idle, ~w_full};

    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_rdata <= '0;
        end else if (bus.bus_addr == BASE_ADDR) begin
            r_rdata <= w_status;
        end else begin
            r_rdata <= '0;
        end
    end

    // busy uses the current level (so it trails a push by one edge) and the
    // next state (so it drops on the same edge IDLE is re-entered).
    always_ff @(posedge clock) begin
        if (!n_rst) begin
            r_tx   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_tx   <= w_tx;
            r_busy <= !w_empty || (w_state_next != S_IDLE);
        end
    end

    assign bus.bus_rdata = r_rdata;
    assign tx            = r_tx;
    assign busy          = r_busy;

endmodule

// File: tb/tb_uart_tx_fifo_bridge.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo_bridge
// Two instances: dut_a (8N1, FIFO_DEPTH=4, CLKS_PER_BIT=4) and dut_b
// (7E2, CLKS_PER_BIT=4). A UART monitor decodes dut_a's tx line and compares
// each frame against a queue of expected bytes filled as writes are issued.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo_bridge;

    localparam int CPB = 4;

    logic        clock = 1'b0;
    logic        n_rst = 1'b0;
    logic [11:0] addr  = '0;
    logic [15:0] wdata = '0;
    logic        we    = 1'b0;
    logic        sel   = 1'b0;

    logic tx_a, busy_a, tx_b, busy_b;

    int total   = 0;
    int bad     = 0;
    int cyc     = 0;
    int rst_cnt = 0;
    int frames  = 0;

    logic [7:0] exp_q    [$];
    int         starts_q [$];

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs [8];

    logic a_bits [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic b_bits [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    uart_tx_fifo_bridge_if if_a ();
    uart_tx_fifo_bridge_if if_b ();

    assign if_a.bus_addr  = addr;
    assign if_a.bus_wdata = wdata;
    assign if_a.bus_we    = we & ~sel;
    assign if_b.bus_addr  = addr;
    assign if_b.bus_wdata = wdata;
    assign if_b.bus_we    = we & sel;

    uart_tx_fifo_bridge #(
        .BASE_ADDR(12'h800), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB),
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)
    ) dut_a (
        .clock(clock), .n_rst(n_rst), .bus(if_a), .tx(tx_a), .busy(busy_a)
    );

    uart_tx_fifo_bridge #(
        .BASE_ADDR(12'h800), .FIFO_DEPTH(8), .CLKS_PER_BIT(CPB),
        .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)
    ) dut_b (
        .clock(clock), .n_rst(n_rst), .bus(if_b), .tx(tx_b), .busy(busy_b)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (!n_rst) rst_cnt <= rst_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a falling edge; the write is sampled at the next rising edge.
    task automatic bus_write(input logic s, input logic [11:0] a, input logic [15:0] d);
        sel   = s;
        addr  = a;
        wdata = d;
        we    = 1'b1;
        @(negedge clock);
        we    = 1'b0;
    endtask

    task automatic bus_read(input logic s, input logic [11:0] a, output logic [15:0] d);
        sel  = s;
        addr = a;
        we   = 1'b0;
        @(negedge clock);
        d = s ? if_b.bus_rdata : if_a.bus_rdata;
    endtask

    task automatic read_check(input logic s, input logic [11:0] a,
                              input logic [15:0] exp, input string name);
        logic [15:0] d;
        bus_read(s, a, d);
        check(name, d, exp);
    endtask

    task automatic wait_idle(input logic s, input int max_cyc, input string name);
        int n = 0;
        while ((s ? busy_b : busy_a) && (n < max_cyc)) begin
            @(negedge clock);
            n++;
        end
        check(name, s ? busy_b : busy_a, 1'b0);
    endtask

    // UART monitor for dut_a: mid-bit sampling, aborts frames cut by reset.
    logic [7:0] m_data;
    logic       m_sb, m_stop;
    int         m_start, m_rst;

    initial begin
        forever begin
            @(negedge clock);
            if (n_rst && (tx_a === 1'b0)) begin
                m_start = cyc;
                m_rst   = rst_cnt;
                repeat (CPB / 2) @(negedge clock);
                m_sb = tx_a;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clock);
                    m_data[i] = tx_a;
                end
                repeat (CPB) @(negedge clock);
                m_stop = tx_a;
                if (rst_cnt == m_rst) begin
                    frames++;
                    starts_q.push_back(m_start);
                    check("frame_start_bit", m_sb, 1'b0);
                    check("frame_stop_bit", m_stop, 1'b1);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame: got 0x%0h expected none", m_data);
                    end else begin
                        check("frame_data", m_data, exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int f0;
        logic [15:0] d;

        vecs[0] = '{we: 1'b0, addr: 12'h800, wdata: 16'h0000, exp: 16'h0003};
        vecs[1] = '{we: 1'b0, addr: 12'h801, wdata: 16'h0000, exp: 16'h0000};
        vecs[2] = '{we: 1'b0, addr: 12'h7FF, wdata: 16'h0000, exp: 16'h0000};
        vecs[3] = '{we: 1'b1, addr: 12'h803, wdata: 16'h00AA, exp: 16'h0000};
        vecs[4] = '{we: 1'b0, addr: 12'h800, wdata: 16'h0000, exp: 16'h0003};
        vecs[5] = '{we: 1'b1, addr: 12'h800, wdata: 16'hFFFB, exp: 16'h0000};
        vecs[6] = '{we: 1'b0, addr: 12'h800, wdata: 16'h0000, exp: 16'h0003};
        vecs[7] = '{we: 1'b0, addr: 12'h802, wdata: 16'h0000, exp: 16'h0000};

        // ---- reset / idle ----
        n_rst = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", tx_a, 1'b1);
        check("rst_busy", busy_a, 1'b0);
        check("rst_rdata", if_a.bus_rdata, 16'h0000);
        n_rst = 1'b1;
        @(negedge clock);
        check("idle_tx", tx_a, 1'b1);
        check("idle_busy", busy_a, 1'b0);

        // ---- register map vectors ----
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].we) begin
                bus_write(1'b0, vecs[i].addr, vecs[i].wdata);
            end else begin
                bus_read(1'b0, vecs[i].addr, d);
                check($sformatf("vec%0d", i), d, vecs[i].exp);
            end
        end
        read_check(1'b1, 12'h800, 16'h0003, "b_idle_status");

        // ---- single frame 0xA5, cycle-exact line check ----
        exp_q.push_back(8'hA5);
        bus_write(1'b0, 12'h801, 16'h00A5);
        check("single_busy_n", busy_a, 1'b0);
        check("single_tx_n", tx_a, 1'b1);
        @(negedge clock);
        check("single_busy_n1", busy_a, 1'b1);
        check("single_tx_n1", tx_a, 1'b1);
        for (int j = 0; j < 40; j++) begin
            @(negedge clock);
            check($sformatf("single_tx_c%0d", j), tx_a, a_bits[j / CPB]);
            if (j == 38) check("single_busy_last_stop", busy_a, 1'b1);
            if (j == 39) check("single_busy_fall", busy_a, 1'b0);
        end
        check("single_frames", frames, 1);
        check("single_q_empty", exp_q.size(), 0);

        // ---- back-to-back with level readback ----
        starts_q.delete();
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        exp_q.push_back(8'h33);
        bus_write(1'b0, 12'h801, 16'h005A);
        bus_write(1'b0, 12'h801, 16'h0011);
        bus_write(1'b0, 12'h801, 16'h0022);
        bus_write(1'b0, 12'h801, 16'h0033);
        read_check(1'b0, 12'h800, 16'h0301, "b2b_level3");
        repeat (45) @(negedge clock);
        read_check(1'b0, 12'h800, 16'h0201, "b2b_level2");
        wait_idle(1'b0, 500, "b2b_idle_timeout");
        repeat (2) @(negedge clock);
        check("b2b_frame_count", starts_q.size(), 4);
        if (starts_q.size() == 4) begin
            for (int k = 1; k < 4; k++)
                check($sformatf("b2b_gap%0d", k), starts_q[k] - starts_q[k-1], 10 * CPB);
        end
        check("b2b_q_empty", exp_q.size(), 0);

        // ---- overflow, clear, and push-while-full with simultaneous pop ----
        for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h41 + k));
        bus_write(1'b0, 12'h801, 16'h0041);
        n0 = cyc;
        for (int k = 1; k < 6; k++) bus_write(1'b0, 12'h801, 16'(16'h0041 + k));
        read_check(1'b0, 12'h800, 16'h0404, "ovf_status");
        bus_write(1'b0, 12'h800, 16'h0004);
        read_check(1'b0, 12'h800, 16'h0400, "ovf_cleared");
        while (cyc < n0 + 40) @(negedge clock);
        exp_q.push_back(8'h47);
        bus_write(1'b0, 12'h801, 16'h0047);
        read_check(1'b0, 12'h800, 16'h0400, "full_push_pop");
        wait_idle(1'b0, 1000, "ovf_idle_timeout");
        repeat (2) @(negedge clock);
        check("ovf_q_empty", exp_q.size(), 0);
        read_check(1'b0, 12'h800, 16'h0003, "ovf_final_status");

        // ---- reset in the middle of a frame ----
        f0 = frames;
        bus_write(1'b0, 12'h801, 16'h0080);
        bus_write(1'b0, 12'h801, 16'h0082);
        bus_write(1'b0, 12'h801, 16'h0083);
        read_check(1'b0, 12'h800, 16'h0201, "mid_level");
        repeat (4) @(negedge clock);
        check("mid_tx_in_data", tx_a, 1'b0);
        n_rst = 1'b0;
        @(negedge clock);
        check("mid_rst_tx", tx_a, 1'b1);
        check("mid_rst_busy", busy_a, 1'b0);
        check("mid_rst_rdata", if_a.bus_rdata, 16'h0000);
        n_rst = 1'b1;
        read_check(1'b0, 12'h800, 16'h0003, "mid_rst_status");
        repeat (150) @(negedge clock);
        check("mid_no_frames", frames, f0);
        check("mid_tx_high", tx_a, 1'b1);
        check("mid_busy_low", busy_a, 1'b0);

        // ---- 7E2 frame on dut_b ----
        bus_write(1'b1, 12'h801, 16'h0007);
        @(negedge clock);
        check("par_busy", busy_b, 1'b1);
        for (int j = 0; j < 44; j++) begin
            @(negedge clock);
            check($sformatf("par_tx_c%0d", j), tx_b, b_bits[j / CPB]);
        end
        wait_idle(1'b1, 20, "par_idle_timeout");
        read_check(1'b1, 12'h800, 16'h0003, "par_final_status");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
